// File: rtl/burst_mem_responder.sv
// Synthesizable cacheline memory behind the CPU burst port: answers each
// 256-bit line request with four 64-bit beats after a fixed access latency.
module burst_mem_responder #(
  parameter int DEPTH_LINES = 64,
  parameter int LATENCY     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_address,
  input  logic [63:0] mem_wdata,
  output logic [63:0] mem_rdata,
  output logic        mem_resp,
  output logic        protocol_err
);

  localparam int IDX_W = $clog2(DEPTH_LINES);
  localparam int CNT_W = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {IDLE, WAIT, BURST, TURN} state_t;

  state_t             state;
  logic [CNT_W-1:0]   lat_cnt;
  logic [1:0]         beat;
  logic [31:0]        addr_q;
  logic [1:0]         req_q;
  logic               op_read;

  logic [255:0]       mem [DEPTH_LINES];
  logic [IDX_W-1:0]   line_idx;
  logic [255:0]       cur_line;
  logic               req_chg;

  assign line_idx = addr_q[5 +: IDX_W];
  assign cur_line = mem[line_idx];
  // Any wobble on address or request lines while a burst is owned is an initiator bug.
  assign req_chg  = (mem_address != addr_q) || ({mem_read, mem_write} != req_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      lat_cnt      <= '0;
      beat         <= '0;
      mem_resp     <= 1'b0;
      mem_rdata    <= '0;
      protocol_err <= 1'b0;
      addr_q       <= '0;
      req_q        <= '0;
      op_read      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_read || mem_write) begin
            addr_q  <= mem_address;
            req_q   <= {mem_read, mem_write};
            op_read <= mem_read;
            lat_cnt <= '0;
            state   <= WAIT;
            if (mem_read && mem_write) protocol_err <= 1'b1;
          end
        end
        WAIT: begin
          if (req_chg) protocol_err <= 1'b1;
          if (lat_cnt == CNT_W'(LATENCY - 1)) begin
            state     <= BURST;
            beat      <= '0;
            mem_resp  <= 1'b1;
            mem_rdata <= op_read ? cur_line[63:0] : '0;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        BURST: begin
          if (req_chg) protocol_err <= 1'b1;
          beat <= beat + 2'd1;
          if (beat == 2'd3) begin
            state     <= TURN;
            mem_resp  <= 1'b0;
            mem_rdata <= '0;
          end else begin
            // Prefetch the next beat so it lands together with its resp strobe.
            mem_rdata <= op_read ? cur_line[{beat + 2'd1, 6'd0} +: 64] : '0;
          end
        end
        TURN: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Storage is never reset; write beats land on the edge ending each resp cycle.
  always_ff @(posedge clk) begin
    if (state == BURST && !op_read)
      mem[line_idx][{beat, 6'd0} +: 64] <= mem_wdata;
  end

endmodule

// File: tb/tb_burst_mem_responder.sv
// Directed bench for burst_mem_responder: a driver issues bursts and queues
// expected read beats; a negedge monitor pops and compares them.
module tb_burst_mem_responder;
  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] mem_address = '0;
  logic [63:0] mem_wdata = '0;
  logic [63:0] mem_rdata;
  logic        mem_resp;
  logic        protocol_err;

  burst_mem_responder #(.DEPTH_LINES(64), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_resp(mem_resp), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  logic [63:0] exp_q[$];

  localparam logic [255:0] L1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
  localparam logic [255:0] L2 = {64'hDEAD_BEEF_0000_0004, 64'hDEAD_BEEF_0000_0003,
                                 64'hDEAD_BEEF_0000_0002, 64'hDEAD_BEEF_0000_0001};
  localparam logic [255:0] L3 = {64'hA5A5_0000_0000_0003, 64'hA5A5_0000_0000_0002,
                                 64'hA5A5_0000_0000_0001, 64'hA5A5_0000_0000_0000};
  localparam logic [255:0] L4 = {64'hFFFF_FFFF_FFFF_FFFF, 64'hEEEE_EEEE_EEEE_EEEE,
                                 64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC};
  localparam logic [255:0] L5 = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                                 64'h5555_AAAA_5555_AAAA, 64'h7777_0000_7777_0000};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push_line(input logic [255:0] line);
    for (int k = 0; k < 4; k++) exp_q.push_back(line[64*k +: 64]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one burst starting in the current cycle; returns the cycle of the first resp.
  task automatic burst(input bit rd, input bit wr, input logic [31:0] addr,
                       input logic [255:0] line, input int drop_at, input int abort_at,
                       input bit hold, output int first);
    int k;
    int cyc;
    bit gap;
    mem_read = rd; mem_write = wr; mem_address = addr; mem_wdata = line[63:0];
    k = 0; cyc = 0; first = -1; gap = 0;
    while (k < 4 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (mem_resp) begin
        if (k == 0) first = cyc;
        if (k == abort_at) begin
          #2 rst = 1'b0;
          #1;
          check("async_resp", 64'(mem_resp), 64'd0);
          check("async_rdata", mem_rdata, 64'd0);
          mem_read = 1'b0; mem_write = 1'b0;
          exp_q.delete();
          return;
        end
        mem_wdata = line[64*k +: 64];
        if (k == drop_at) mem_write = 1'b0;
        k++;
      end else if (k > 0) begin
        gap = 1'b1;
      end
    end
    check("burst_beats", 64'(k), 64'd4);
    check("contiguous", 64'(gap), 64'd0);
    if (!hold) begin
      @(posedge clk); #1;
      mem_read = 1'b0; mem_write = 1'b0;
    end
  endtask

  task automatic reset_pulse();
    rst = 1'b0;
    #1;
    check("err_cleared", 64'(protocol_err), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    idle(1);
  endtask

  // Monitor: read beats against the scoreboard, rdata must be 0 outside resp.
  always @(negedge clk) begin
    if (rst) begin
      if (mem_resp && mem_read) begin
        if (exp_q.size() == 0) check("unexpected_beat", 64'd1, 64'd0);
        else check("rdata", mem_rdata, exp_q.pop_front());
      end else if (!mem_resp) begin
        check("rdata_idle", mem_rdata, 64'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int f, f2;
    #2 rst = 1'b0;
    #1;
    check("reset_resp", 64'(mem_resp), 64'd0);
    check("reset_rdata", mem_rdata, 64'd0);
    check("reset_err", 64'(protocol_err), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    idle(1);

    // Write then read line 3
    burst(0, 1, 32'h60, L1, 4, 4, 0, f);
    check("wr_latency", 64'(f), 64'(LAT + 1));
    idle(1);
    push_line(L1);
    burst(1, 0, 32'h60, L1, 4, 4, 0, f);
    check("rd_latency", 64'(f), 64'(LAT + 1));
    idle(1);

    // Aliasing onto line 0
    burst(0, 1, 32'h0000_0805, L2, 4, 4, 0, f);
    idle(1);
    push_line(L2);
    burst(1, 0, 32'h0, L2, 4, 4, 0, f);
    check("alias_err", 64'(protocol_err), 64'd0);
    idle(1);

    // Back-to-back reads with mem_read held through TURN
    push_line(L1);
    push_line(L1);
    burst(1, 0, 32'h60, L1, 4, 4, 1, f);
    burst(1, 0, 32'h60, L1, 4, 4, 0, f2);
    check("b2b_gap", 64'(f2), 64'(LAT + 3));
    idle(1);

    // Read and write together: read wins, line untouched, sticky error
    burst(0, 1, 32'h40, L3, 4, 4, 0, f);
    idle(1);
    check("err_before_both", 64'(protocol_err), 64'd0);
    push_line(L3);
    burst(1, 1, 32'h40, L4, 4, 4, 0, f);
    check("both_err", 64'(protocol_err), 64'd1);
    idle(1);
    push_line(L3);
    burst(1, 0, 32'h40, L3, 4, 4, 0, f);
    check("both_err_sticky", 64'(protocol_err), 64'd1);
    reset_pulse();

    // mem_write dropped after beat 1
    burst(0, 1, 32'h40, L5, 2, 4, 0, f);
    check("drop_err", 64'(protocol_err), 64'd1);
    reset_pulse();
    push_line(L5);
    burst(1, 0, 32'h40, L5, 4, 4, 0, f);
    idle(1);

    // Reset during beat 2 of a read, then re-read
    push_line(L1);
    burst(1, 0, 32'h60, L1, 4, 2, 0, f);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    idle(1);
    push_line(L1);
    burst(1, 0, 32'h60, L1, 4, 4, 0, f);
    check("post_abort_err", 64'(protocol_err), 64'd0);
    idle(2);
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/burst_mem_responder.md
Name: burst_mem_responder

Overview:
Synthesizable physical-memory responder for the CPU's burst memory port (pmem_read/pmem_write/pmem_address/pmem_wdata/pmem_rdata/pmem_resp). It receives 256-bit cacheline requests from the cache-line adapter and answers with four 64-bit beats after a programmable access latency. It stands in for the burst memory model in synthesizable/FPGA builds and in unit-level cache benches.

Parameters:
DEPTH_LINES, 64, number of 256-bit lines stored; power of two, at least 2.
LATENCY, 4, idle cycles between request acceptance and the first resp beat; at least 1.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous, active-low reset.
mem_read  input  1  read-burst request; held high until the 4th resp.
mem_write  input  1  write-burst request; held high until the 4th resp.
mem_address  input  32  line address; bits [4:0] ignored, line index = mem_address[5 +: log2(DEPTH_LINES)], upper bits ignored (aliasing).
mem_wdata  input  64  write beat; beat k must be valid on the cycle of the k-th resp.
mem_rdata  output  64  read beat; valid only while mem_resp is high on a read.
mem_resp  output  1  beat strobe; high for exactly 4 consecutive cycles per burst.
protocol_err  output  1  sticky error flag; cleared only by reset.

Behaviour:
- Reset (rst low, asynchronous): state IDLE, latency counter 0, beat counter 0, mem_resp 0, mem_rdata 0, protocol_err 0. Storage array is not cleared. Reset mid-burst aborts the burst immediately. On a write, beats already written stay written.
- State machine: IDLE, WAIT, BURST, TURN.
- IDLE: on (mem_read or mem_write):
  - latch the line index and the op (read has priority if both are high; both high sets protocol_err).
  - clear the latency counter and go to WAIT.
- WAIT: counts LATENCY cycles with mem_resp 0, then goes to BURST. The first resp appears LATENCY+1 cycles after the request is first sampled.
- BURST: mem_resp 1 for beats 0..3, beat counter increments each cycle and wraps from 3 back to 0.
  - Read: mem_rdata = line[64*k +: 64] in the same cycle as resp (registered read, prefetched one cycle earlier).
  - Write: line[64*k +: 64] <= mem_wdata on each resp edge.
  - After beat 3, go to TURN.
- TURN: one cycle with mem_resp 0 and requests ignored, then IDLE. Back-to-back requests are therefore separated by at least one idle cycle.
- Request checking:
  - The latched address and op are used for the whole burst. Changes to mem_address or the op mid-burst are ignored and set protocol_err.
  - Request deasserted before beat 3: the burst still completes all 4 beats and protocol_err is set.
  - Request still high in TURN: treated as a new request when the state returns to IDLE. Initiators deassert on the cycle after the 4th resp.
- mem_rdata is 0 whenever mem_resp is 0.
- Write-then-read of the same line returns the new data; no forwarding is needed because of TURN.

Test Plan:
- Reset, then write line 3 (addr 0x60) with beats 0x1111..., 0x2222..., 0x3333..., 0x4444...; then read 0x60. Required: the first resp comes LATENCY+1=5 cycles after the request, the 4 resp cycles are contiguous, and the read returns the same beats in order.
- Aliasing: write addr 0x0000_0805 (line 0, bits [4:0] ignored, bit 11 aliased away) then read 0x0. Required: identical data and protocol_err stays 0.
- Back-to-back: hold mem_read across the TURN cycle. Required: mem_resp is low for exactly the TURN cycle plus LATENCY+1 WAIT cycles, then a second 4-beat burst follows.
- mem_read and mem_write both high at 0x40. Required: a read burst is performed, line 2 is unchanged, and protocol_err=1 until rst is driven low.
- Drop mem_write after beat 1. Required: 4 resps still issued, beats 2 and 3 take whatever mem_wdata was, and protocol_err=1.
- Assert rst low during beat 2 of a read. Required: mem_resp and mem_rdata go to 0 asynchronously, and after release a fresh read of the same line returns the correct data.
